// File: rtl/ready_counter_pkg.sv
// Shared types and parameter defaults for the register-ready event counter.
// The debug struct mirrors the FSM state and reset synchronizer stages.
package ready_counter_pkg;

  localparam int unsigned DEPTH_DEFAULT         = 16;
  localparam int unsigned AUTO_RESTART_DEFAULT  = 0;
  localparam int unsigned ALMOST_MARGIN_DEFAULT = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    FULL     = 2'd2
  } state_t;

  typedef struct packed {
    state_t state;
    logic   arm;
    logic   rst_sync_n;
  } dbg_t;

endpackage

// File: rtl/ready_counter_reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchronizer (two flops).
// Both stages clear immediately when rst_n_i falls and fill with ones after release.
module reset_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic arm_o,
  output logic rst_sync_n_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign arm_o        = sync_q[0];
  assign rst_sync_n_o = sync_q[1];

endmodule

// File: rtl/ready_counter.sv
// Counts rising edges of register_ready up to DEPTH, with full/almost_full
// flags and a one-cycle full_pulse; optionally wraps back to zero after full.
module ready_counter
  import ready_counter_pkg::*;
#(
  parameter int unsigned DEPTH         = DEPTH_DEFAULT,
  parameter int unsigned AUTO_RESTART  = AUTO_RESTART_DEFAULT,
  parameter int unsigned ALMOST_MARGIN = ALMOST_MARGIN_DEFAULT
) (
  input  logic                       register_ready,
  input  logic                       rst_n,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       full_pulse,
  output dbg_t                       dbg_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH_C = CW'(DEPTH - ALMOST_MARGIN);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if (DEPTH < 2 || DEPTH > 65535) begin : g_bad_depth
    $fatal(1, "ready_counter: DEPTH must be in 2..65535");
  end
  if (ALMOST_MARGIN < 1 || ALMOST_MARGIN >= DEPTH) begin : g_bad_margin
    $fatal(1, "ready_counter: ALMOST_MARGIN must be in 1..DEPTH-1");
  end
  if (AUTO_RESTART > 1) begin : g_bad_restart
    $fatal(1, "ready_counter: AUTO_RESTART must be 0 or 1");
  end

  logic   arm;
  logic   rst_sync_n;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic   pulse_q, pulse_d;

  reset_sync u_reset_sync (
    .clk_i        (register_ready),
    .rst_n_i      (rst_n),
    .arm_o        (arm),
    .rst_sync_n_o (rst_sync_n)
  );

  // Counter flops clear straight from rst_n so assertion is immediate. While
  // the first synchronizer stage is low the next state equals the reset value,
  // so a release near an edge cannot disturb them; that stage going high lets
  // the second edge after release be the first one counted.
  always_ff @(posedge register_ready or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = COUNTING;
          cnt_d   = ONE_C;
        end
      end
      COUNTING: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_d == DEPTH_C) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (AUTO_RESTART != 0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    pulse_d = (state_d == FULL) && (state_q != FULL);
  end

  assign full        = (state_q == FULL);
  assign count       = cnt_q;
  assign almost_full = (cnt_q >= AF_TH_C);
  assign full_pulse  = pulse_q;

  assign dbg_o.state      = state_q;
  assign dbg_o.arm        = arm;
  assign dbg_o.rst_sync_n = rst_sync_n;

endmodule

// File: tb/tb_ready_counter.sv
// Directed bench for ready_counter: three parameterisations share one clock
// and reset; a vector table covers the main run, hand sequences cover resets.
module tb_ready_counter;
  import ready_counter_pkg::*;

  logic       register_ready;
  logic       rst_n;

  logic       full16, af16, pulse16;
  logic [4:0] cnt16;
  dbg_t       dbg16;
  logic       full4, af4, pulse4;
  logic [2:0] cnt4;
  dbg_t       dbg4;
  logic       full2, af2, pulse2;
  logic [1:0] cnt2;
  dbg_t       dbg2;

  int n_cmp;
  int n_fail;

  typedef struct {
    int   e;
    int   cnt;
    logic full;
    logic af;
    logic pulse;
  } vec_t;

  vec_t v16[10];

  ready_counter #(.DEPTH(16), .AUTO_RESTART(0), .ALMOST_MARGIN(1)) u_d16 (
    .register_ready (register_ready), .rst_n (rst_n), .full (full16),
    .count (cnt16), .almost_full (af16), .full_pulse (pulse16), .dbg_o (dbg16)
  );
  ready_counter #(.DEPTH(4), .AUTO_RESTART(1), .ALMOST_MARGIN(1)) u_d4 (
    .register_ready (register_ready), .rst_n (rst_n), .full (full4),
    .count (cnt4), .almost_full (af4), .full_pulse (pulse4), .dbg_o (dbg4)
  );
  ready_counter #(.DEPTH(2), .AUTO_RESTART(0), .ALMOST_MARGIN(1)) u_d2 (
    .register_ready (register_ready), .rst_n (rst_n), .full (full2),
    .count (cnt2), .almost_full (af2), .full_pulse (pulse2), .dbg_o (dbg2)
  );

  // clock / reset
  initial begin
    register_ready = 1'b0;
    forever #5 register_ready = ~register_ready;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one rising edge, then sample on the following falling edge
  task automatic step();
    @(posedge register_ready);
    @(negedge register_ready);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check16(input string tag, input int c, input int f, input int a, input int p);
    check({tag, " d16 count"}, int'(cnt16), c);
    check({tag, " d16 full"}, int'(full16), f);
    check({tag, " d16 almost_full"}, int'(af16), a);
    check({tag, " d16 full_pulse"}, int'(pulse16), p);
  endtask

  // assert reset while register_ready is low and check the immediate effect
  task automatic reset_now(input string tag);
    #2 rst_n = 1'b0;
    #1 check16(tag, 0, 0, 0, 0);
    check({tag, " d16 state"}, int'(dbg16.state), int'(IDLE));
    @(negedge register_ready);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    int k;
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;

    // e = rising edges since rst_n release; counted edges = e-1
    v16[0] = '{1,  0,  1'b0, 1'b0, 1'b0};
    v16[1] = '{2,  1,  1'b0, 1'b0, 1'b0};
    v16[2] = '{3,  2,  1'b0, 1'b0, 1'b0};
    v16[3] = '{10, 9,  1'b0, 1'b0, 1'b0};
    v16[4] = '{15, 14, 1'b0, 1'b0, 1'b0};
    v16[5] = '{16, 15, 1'b0, 1'b1, 1'b0};
    v16[6] = '{17, 16, 1'b1, 1'b1, 1'b1};
    v16[7] = '{18, 16, 1'b1, 1'b1, 1'b0};
    v16[8] = '{25, 16, 1'b1, 1'b1, 1'b0};
    v16[9] = '{32, 16, 1'b1, 1'b1, 1'b0};

    #1 check16("reset", 0, 0, 0, 0);
    check("reset d4 count", int'(cnt4), 0);
    check("reset d2 full", int'(full2), 0);
    check("reset d16 state", int'(dbg16.state), int'(IDLE));

    #19 rst_n = 1'b1;  // release at 20 ns

    idx = 0;
    for (int e = 1; e <= 32; e++) begin
      step();
      k = e - 1;
      if (idx < 10 && v16[idx].e == e) begin
        check16($sformatf("vec e%0d", e), v16[idx].cnt, int'(v16[idx].full),
                int'(v16[idx].af), int'(v16[idx].pulse));
        idx++;
      end
      if (e == 17) check("d16 state at full", int'(dbg16.state), int'(FULL));
      if (e <= 12) begin
        check($sformatf("d4 count e%0d", e), int'(cnt4), (k == 0) ? 0 : k % 5);
        check($sformatf("d4 full e%0d", e), int'(full4), int'(k > 0 && k % 5 == 4));
        check($sformatf("d4 pulse e%0d", e), int'(pulse4), int'(k > 0 && k % 5 == 4));
        check($sformatf("d4 almost_full e%0d", e), int'(af4), int'(k > 0 && k % 5 >= 3));
      end
      if (e <= 5) begin
        check($sformatf("d2 count e%0d", e), int'(cnt2), (k > 2) ? 2 : k);
        check($sformatf("d2 full e%0d", e), int'(full2), int'(k >= 2));
        check($sformatf("d2 almost_full e%0d", e), int'(af2), int'(k >= 1));
        check($sformatf("d2 pulse e%0d", e), int'(pulse2), int'(k == 2));
      end
    end

    // reset while FULL, then count to 9 and reset mid-count
    reset_now("rst in full");
    steps(10);
    check16("pre mid-rst", 9, 0, 0, 0);
    reset_now("rst mid-count");
    step();
    check16("restart e1", 0, 0, 0, 0);
    step();
    check16("restart e2", 1, 0, 0, 0);

    // full needs a fresh DEPTH counted edges after a reset taken while FULL
    steps(15);
    check16("refill e17", 16, 1, 1, 1);
    reset_now("rst in full 2");
    steps(16);
    check16("refill2 e16", 15, 0, 1, 0);
    step();
    check16("refill2 e17", 16, 1, 1, 1);
    step();
    check16("refill2 e18", 16, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
